// File: rtl/mlp_classifier.sv
// N_IN-N_HID-1 sigmoid perceptron with runtime-loadable weights.
// One shared MAC and one shared PLAN sigmoid are time-multiplexed by the FSM.
module mlp_classifier #(
  parameter int unsigned N_IN    = 2,
  parameter int unsigned N_HID   = 2,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned FRAC_W  = 10,
  localparam int unsigned W_DEPTH = N_HID * (N_IN + 1) + N_HID + 1,
  localparam int unsigned AW      = $clog2(W_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*DATA_W-1:0]   x_in,
  input  logic                     w_we,
  input  logic [AW-1:0]            w_addr,
  input  logic [DATA_W-1:0]        w_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        y,
  output logic                     cl,
  output logic                     busy
);

  localparam int unsigned MX    = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int unsigned PW    = 2 * DATA_W;
  localparam int unsigned ACC_W = PW + $clog2(MX + 1);
  localparam int unsigned XIW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned HIW   = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int unsigned CW    = (XIW > HIW) ? XIW : HIW;
  localparam int unsigned OB    = N_HID * (N_IN + 1);
  localparam int unsigned AB    = DATA_W + 1;

  localparam logic [AB-1:0]     ONE   = AB'(1) << FRAC_W;
  localparam logic [AB-1:0]     T_5   = AB'(5) << FRAC_W;
  localparam logic [AB-1:0]     T_2P4 = AB'(19) << (FRAC_W - 3);
  localparam logic [AB-1:0]     C_HI  = AB'(27) << (FRAC_W - 5);
  localparam logic [AB-1:0]     C_MID = AB'(5) << (FRAC_W - 3);
  localparam logic [AB-1:0]     C_LO  = AB'(1) << (FRAC_W - 1);
  localparam logic [DATA_W-1:0] HALF  = DATA_W'(1) << (FRAC_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HBIAS, ST_HMAC, ST_HACT, ST_OBIAS, ST_OMAC, ST_OACT, ST_DONE
  } state_e;

  state_e state_q, state_d;

  logic signed [DATA_W-1:0] w_q   [W_DEPTH];
  logic signed [DATA_W-1:0] x_q   [N_IN];
  logic signed [DATA_W-1:0] hid_q [N_HID];
  logic        [HIW-1:0]    hidx_q;
  logic        [CW-1:0]     idx_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic        [DATA_W-1:0] y_q;
  logic                     cl_q;
  logic                     out_valid_q;

  logic        [AW-1:0]     widx_c;
  logic signed [DATA_W-1:0] wsel_c, opnd_c, sat_c;
  logic signed [PW-1:0]     prod_c, term_c;
  logic signed [ACC_W-1:0]  bias_ext_c, term_ext_c;
  logic        [DATA_W-1:0] sig_c;
  logic                     accept_c, wr_c;

  // PLAN sigmoid on a saturated activation; negative inputs mirror around 0.5
  function automatic logic [DATA_W-1:0] sig_f(input logic signed [DATA_W-1:0] v);
    logic [AB-1:0] ext, a, f;
    ext = {v[DATA_W-1], v};
    a   = v[DATA_W-1] ? (~ext + AB'(1)) : ext;
    if (a >= T_5)        f = ONE;
    else if (a >= T_2P4) f = (a >> 5) + C_HI;
    else if (a >= ONE)   f = (a >> 3) + C_MID;
    else                 f = (a >> 2) + C_LO;
    if (v[DATA_W-1]) f = ONE - f;
    return DATA_W'(f);
  endfunction

  assign in_ready  = rst & en & (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign cl        = cl_q;
  assign accept_c  = in_valid & in_ready;
  assign wr_c      = w_we & en & (state_q == ST_IDLE) &
                     ({1'b0, w_addr} < (AW + 1)'(W_DEPTH));

  // Weight address and second MAC operand for the current step
  always_comb begin
    widx_c = '0;
    opnd_c = '0;
    case (state_q)
      ST_HBIAS: widx_c = AW'(hidx_q) * AW'(N_IN + 1) + AW'(N_IN);
      ST_HMAC: begin
        widx_c = AW'(hidx_q) * AW'(N_IN + 1) + AW'(idx_q);
        opnd_c = x_q[idx_q[XIW-1:0]];
      end
      ST_OBIAS: widx_c = AW'(OB + N_HID);
      ST_OMAC: begin
        widx_c = AW'(OB) + AW'(idx_q);
        opnd_c = hid_q[idx_q[HIW-1:0]];
      end
      default: ;
    endcase
  end

  assign wsel_c     = w_q[widx_c];
  assign prod_c     = wsel_c * opnd_c;
  assign term_c     = prod_c >>> FRAC_W;
  assign bias_ext_c = $signed({{(ACC_W - DATA_W){wsel_c[DATA_W-1]}}, wsel_c});
  assign term_ext_c = $signed({{(ACC_W - PW){term_c[PW-1]}}, term_c});

  // Clamp the accumulator to a signed DATA_W value
  always_comb begin
    if (acc_q[ACC_W-1:DATA_W-1] == {(ACC_W - DATA_W + 1){acc_q[ACC_W-1]}})
      sat_c = acc_q[DATA_W-1:0];
    else if (acc_q[ACC_W-1])
      sat_c = {1'b1, {(DATA_W - 1){1'b0}}};
    else
      sat_c = {1'b0, {(DATA_W - 1){1'b1}}};
  end

  assign sig_c = sig_f(sat_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        ST_IDLE:  if (accept_c) state_d = ST_HBIAS;
        ST_HBIAS: state_d = ST_HMAC;
        ST_HMAC:  if (idx_q == CW'(N_IN - 1)) state_d = ST_HACT;
        ST_HACT:  state_d = (hidx_q == HIW'(N_HID - 1)) ? ST_OBIAS : ST_HBIAS;
        ST_OBIAS: state_d = ST_OMAC;
        ST_OMAC:  if (idx_q == CW'(N_HID - 1)) state_d = ST_OACT;
        ST_OACT:  state_d = ST_DONE;
        ST_DONE:  if (out_valid_q && out_ready) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath: weights, latched sample, accumulator, hidden activations, result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < W_DEPTH; k++) w_q[k] <= '0;
      for (int k = 0; k < N_IN; k++)    x_q[k] <= '0;
      for (int k = 0; k < N_HID; k++)   hid_q[k] <= '0;
      hidx_q      <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      cl_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      if (wr_c) w_q[w_addr] <= w_data;
      case (state_q)
        ST_IDLE: if (accept_c) begin
          for (int k = 0; k < N_IN; k++) x_q[k] <= x_in[k*DATA_W +: DATA_W];
          hidx_q <= '0;
        end
        ST_HBIAS, ST_OBIAS: begin
          acc_q <= bias_ext_c;
          idx_q <= '0;
        end
        ST_HMAC, ST_OMAC: begin
          acc_q <= acc_q + term_ext_c;
          idx_q <= idx_q + CW'(1);
        end
        ST_HACT: begin
          hid_q[hidx_q] <= sig_c;
          if (hidx_q != HIW'(N_HID - 1)) hidx_q <= hidx_q + HIW'(1);
        end
        ST_OACT: begin
          y_q  <= sig_c;
          cl_q <= (sig_c >= HALF);
        end
        ST_DONE: begin
          if (!out_valid_q)    out_valid_q <= 1'b1;
          else if (out_ready)  out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_classifier.sv
// Self-checking bench for mlp_classifier (2-2-1) against an integer reference model.
module tb_mlp_classifier;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, in_ready, w_we, out_valid, out_ready, cl, busy;
  logic [31:0] x_in;
  logic [3:0]  w_addr;
  logic [15:0] w_data, y;

  int n_vec = 0;
  int n_err = 0;
  int wm [9];

  localparam int LAT = 2 * (2 + 2) + 2 + 3;

  mlp_classifier dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .cl(cl), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sig_m(input int v);
    int a, f;
    a = (v < 0) ? -v : v;
    if (a >= 5120)      f = 1024;
    else if (a >= 2432) f = a / 32 + 864;
    else if (a >= 1024) f = a / 8 + 640;
    else                f = a / 4 + 512;
    return (v < 0) ? 1024 - f : f;
  endfunction

  function automatic int sat_m(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int model_y(input int x0, input int x1);
    int xv [2];
    int hv [2];
    int acc;
    xv[0] = x0;
    xv[1] = x1;
    for (int h = 0; h < 2; h++) begin
      acc = wm[h*3 + 2];
      for (int i = 0; i < 2; i++) acc += (wm[h*3 + i] * xv[i]) >>> 10;
      hv[h] = sig_m(sat_m(acc));
    end
    acc = wm[8];
    for (int h = 0; h < 2; h++) acc += (wm[6 + h] * hv[h]) >>> 10;
    return sig_m(sat_m(acc));
  endfunction

  task automatic wr(input int a, input int d);
    w_we   = 1'b1;
    w_addr = 4'(a);
    w_data = 16'(d);
    @(posedge clk); #1;
    w_we = 1'b0;
    if (a < 9) wm[a] = d;
  endtask

  // Present one sample, optionally stall en and strobe writes while busy
  task automatic run(input int x0, input int x1, input int stall_at, input int stall_len,
                     input bit try_we, output int y_o, output int cl_o, output int lat);
    int c;
    en       = 1'b1;
    x_in     = {16'(x1), 16'(x0)};
    in_valid = 1'b1;
    c = 0;
    while (!in_ready && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    check("in_ready_idle", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_in     = '1;
    lat = 0;
    while (!out_valid && lat < 200) begin
      en     = !(lat >= stall_at && lat < stall_at + stall_len);
      w_we   = try_we;
      w_addr = 4'd8;
      w_data = 16'd5120;
      if (lat == stall_at && stall_len > 0) begin
        #1;
        check("in_ready_stall", int'(in_ready), 0);
        check("busy_stall", int'(busy), 1);
      end
      @(posedge clk); #1;
      lat++;
    end
    en   = 1'b1;
    w_we = 1'b0;
    if (!out_valid) check("out_valid_timeout", 0, 1);
    y_o  = int'(y);
    cl_o = int'(cl);
  endtask

  // Hold the result for some cycles, then complete the output handshake
  task automatic drain(input int hold, input int ey);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_y", int'(y), ey);
      check("hold_cl", int'(cl), int'(ey >= 512));
      check("hold_valid", int'(out_valid), 1);
      check("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_valid", int'(out_valid), 0);
    check("drain_busy", int'(busy), 0);
  endtask

  initial begin
    int yv, cv, lat, ey, x0, x1;
    rst = 1'b0; en = 1'b1; in_valid = 1'b0; x_in = '0;
    w_we = 1'b0; w_addr = '0; w_data = '0; out_ready = 1'b0;
    for (int k = 0; k < 9; k++) wm[k] = 0;

    repeat (3) @(posedge clk); #1;
    check("rst_y", int'(y), 0);
    check("rst_cl", int'(cl), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_busy", int'(busy), 0);

    // all-zero weights
    run(743, 819, 1000, 0, 1'b0, yv, cv, lat);
    check("zero_y", yv, 512);
    check("zero_cl", cv, 1);
    check("zero_lat", lat, LAT);
    drain(0, 512);

    // output bias only
    wr(8, -6144);
    run(100, -200, 1000, 0, 1'b0, yv, cv, lat);
    check("obias_neg_y", yv, 0);
    check("obias_neg_cl", cv, 0);
    drain(0, 0);
    wr(8, 1024);
    run(3000, 5, 1000, 0, 1'b0, yv, cv, lat);
    check("obias_one_y", yv, 768);
    drain(0, 768);
    wr(8, 5120);
    run(-7, 9, 1000, 0, 1'b0, yv, cv, lat);
    check("obias_sat_y", yv, 1024);
    check("obias_sat_cl", cv, 1);
    drain(5, 1024);

    // reset pulse while the output neuron is accumulating
    en = 1'b1; x_in = {16'd1024, 16'd1024}; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_y", int'(y), 0);
    check("midrst_cl", int'(cl), 0);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 9; k++) wm[k] = 0;
    @(posedge clk); #1;
    run(500, -500, 1000, 0, 1'b0, yv, cv, lat);
    check("midrst_cleared_y", yv, model_y(500, -500));
    check("midrst_lat", lat, LAT);
    drain(0, model_y(500, -500));

    // XOR network with hidden biases
    wr(0, 5120); wr(1, 5120); wr(2, -2560);
    wr(3, 5120); wr(4, 5120); wr(5, -7680);
    wr(6, 8192); wr(7, -8192); wr(8, -3072);
    for (int p = 0; p < 4; p++) begin
      x0 = (p & 2) ? 1024 : 0;
      x1 = (p & 1) ? 1024 : 0;
      ey = model_y(x0, x1);
      run(x0, x1, 1000, 0, 1'b0, yv, cv, lat);
      check("xor_y", yv, ey);
      check("xor_cl", cv, ((p & 2) != 0) ^ ((p & 1) != 0));
      drain(0, ey);
    end

    // en stall during hidden MAC, with write strobes that must be ignored
    ey = model_y(0, 1024);
    run(0, 1024, 2, 3, 1'b1, yv, cv, lat);
    check("stall_lat", lat, LAT + 3);
    check("stall_y", yv, ey);
    drain(0, ey);
    run(0, 1024, 1000, 0, 1'b0, yv, cv, lat);
    check("after_we_y", yv, ey);
    drain(0, ey);

    // randomized weights and samples, alternating moderate and full range
    for (int r = 0; r < 10; r++) begin
      for (int a = 0; a < 9; a++)
        wr(a, (r & 1) ? int'($urandom_range(0, 65535)) - 32768
                      : int'($urandom_range(0, 16383)) - 8192);
      wr(9 + int'($urandom_range(0, 6)), int'($urandom_range(0, 65535)) - 32768);
      x0 = (r & 1) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 4095)) - 2048;
      x1 = (r & 1) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 4095)) - 2048;
      ey = model_y(x0, x1);
      run(x0, x1, 1000, 0, 1'b0, yv, cv, lat);
      check("rand_y", yv, ey);
      check("rand_cl", cv, int'(ey >= 512));
      check("rand_lat", lat, LAT);
      drain(0, ey);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
